// File: rtl/timer_sched_pkg.sv
// rtl/timer_sched_pkg.sv - shared FSM states, timer register map and control words
package timer_sched_pkg;

    typedef enum logic [3:0] {
        IDLE,
        STOP,
        PER_L,
        PER_H,
        CLR,
        START,
        WAIT,
        ACK,
        FIN
    } sched_state_t;

    localparam logic [2:0] TMR_STATUS  = 3'd0;
    localparam logic [2:0] TMR_CONTROL = 3'd1;
    localparam logic [2:0] TMR_PERL    = 3'd2;
    localparam logic [2:0] TMR_PERH    = 3'd3;

    localparam logic [15:0] CTRL_STOP              = 16'h0008;
    localparam logic [15:0] CTRL_START_ONESHOT_IRQ = 16'h0005;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after last_grant
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     pending,
    input  logic [IDX_W-1:0] last_grant,
    output logic             valid,
    output logic [IDX_W-1:0] grant
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        valid = 1'b0;
        grant = '0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IDX_W'((int'(last_grant) + k) % N);
            if (!valid && pending[cand]) begin
                valid = 1'b1;
                grant = cand;
            end
        end
    end

endmodule

// File: rtl/timer_delay_scheduler.sv
// rtl/timer_delay_scheduler.sv - shares one interval timer among N_REQ one-shot delay requesters
module timer_delay_scheduler
    import timer_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*32-1:0]   req_delay,
    output logic [N_REQ-1:0]      busy,
    output logic [N_REQ-1:0]      done,
    output logic [N_REQ-1:0]      overrun,
    output logic [2:0]            tmr_address,
    output logic                  tmr_chipselect,
    output logic                  tmr_write_n,
    output logic [15:0]           tmr_writedata,
    input  logic                  tmr_irq
);

    sched_state_t     state;
    logic [31:0]      delay_q [N_REQ];
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] last_grant;
    logic [31:0]      cur_delay;
    logic [31:0]      period;
    logic             arb_valid;
    logic [IDX_W-1:0] arb_grant;

    assign period = cur_delay - 32'd1;

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .pending    (busy),
        .last_grant (last_grant),
        .valid      (arb_valid),
        .grant      (arb_grant)
    );

    // A request landing on the FIN cycle of its own slot refills the slot instead of overrunning.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy    <= '0;
            overrun <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                delay_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req[i] && (!busy[i] || done[i])) begin
                    busy[i]    <= 1'b1;
                    delay_q[i] <= req_delay[32*i +: 32];
                end else if (done[i]) begin
                    busy[i] <= 1'b0;
                end
                if (req[i] && busy[i] && !done[i]) begin
                    overrun[i] <= 1'b1;
                end
            end
        end
    end

    // Bus outputs are registered on entry to each state, so each write holds for exactly that state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            grant          <= '0;
            last_grant     <= IDX_W'(N_REQ - 1);
            cur_delay      <= '0;
            done           <= '0;
            tmr_chipselect <= 1'b0;
            tmr_write_n    <= 1'b1;
            tmr_address    <= '0;
            tmr_writedata  <= '0;
        end else begin
            done           <= '0;
            tmr_chipselect <= 1'b0;
            tmr_write_n    <= 1'b1;
            tmr_address    <= '0;
            tmr_writedata  <= '0;
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        grant     <= arb_grant;
                        cur_delay <= delay_q[arb_grant];
                        if (delay_q[arb_grant] <= 32'd1) begin
                            state <= FIN;
                            done  <= N_REQ'(1) << arb_grant;
                        end else begin
                            state          <= STOP;
                            tmr_chipselect <= 1'b1;
                            tmr_write_n    <= 1'b0;
                            tmr_address    <= TMR_CONTROL;
                            tmr_writedata  <= CTRL_STOP;
                        end
                    end
                end
                STOP: begin
                    state          <= PER_L;
                    tmr_chipselect <= 1'b1;
                    tmr_write_n    <= 1'b0;
                    tmr_address    <= TMR_PERL;
                    tmr_writedata  <= period[15:0];
                end
                PER_L: begin
                    state          <= PER_H;
                    tmr_chipselect <= 1'b1;
                    tmr_write_n    <= 1'b0;
                    tmr_address    <= TMR_PERH;
                    tmr_writedata  <= period[31:16];
                end
                PER_H: begin
                    state          <= CLR;
                    tmr_chipselect <= 1'b1;
                    tmr_write_n    <= 1'b0;
                    tmr_address    <= TMR_STATUS;
                    tmr_writedata  <= '0;
                end
                CLR: begin
                    state          <= START;
                    tmr_chipselect <= 1'b1;
                    tmr_write_n    <= 1'b0;
                    tmr_address    <= TMR_CONTROL;
                    tmr_writedata  <= CTRL_START_ONESHOT_IRQ;
                end
                START: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (tmr_irq) begin
                        state          <= ACK;
                        tmr_chipselect <= 1'b1;
                        tmr_write_n    <= 1'b0;
                        tmr_address    <= TMR_STATUS;
                        tmr_writedata  <= '0;
                    end
                end
                ACK: begin
                    state <= FIN;
                    done  <= N_REQ'(1) << grant;
                end
                FIN: begin
                    last_grant <= grant;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_delay_scheduler.sv
// tb/tb_timer_delay_scheduler.sv - directed self-checking bench with interval timer model
module tb_timer_delay_scheduler;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   req = '0;
    logic [127:0] req_delay = '0;
    logic [3:0]   busy;
    logic [3:0]   done;
    logic [3:0]   overrun;
    logic [2:0]   tmr_address;
    logic         tmr_chipselect;
    logic         tmr_write_n;
    logic [15:0]  tmr_writedata;
    logic         tmr_irq;

    int vecs = 0;
    int errs = 0;
    int cyc = 0;
    int cs_cnt = 0;
    int req_cyc = 0;
    logic [18:0] wr_q[$];
    int          done_idx_q[$];
    int          done_cyc_q[$];

    logic [15:0] m_perl = '0;
    logic [15:0] m_perh = '0;
    logic [31:0] m_cnt = '0;
    logic        m_run = 1'b0;
    logic        m_to = 1'b0;
    logic        m_ito = 1'b0;

    timer_delay_scheduler #(.N_REQ(4), .IDX_W(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .req_delay      (req_delay),
        .busy           (busy),
        .done           (done),
        .overrun        (overrun),
        .tmr_address    (tmr_address),
        .tmr_chipselect (tmr_chipselect),
        .tmr_write_n    (tmr_write_n),
        .tmr_writedata  (tmr_writedata),
        .tmr_irq        (tmr_irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Timer model: not reset by the scheduler's reset, so stale state survives it.
    assign tmr_irq = m_to & m_ito;
    always @(posedge clk) begin
        if (tmr_chipselect && !tmr_write_n) begin
            case (tmr_address)
                3'd0: m_to <= 1'b0;
                3'd1: begin
                    m_ito <= tmr_writedata[0];
                    if (tmr_writedata[3]) m_run <= 1'b0;
                    else if (tmr_writedata[2]) begin
                        m_run <= 1'b1;
                        m_cnt <= {m_perh, m_perl};
                    end
                end
                3'd2: m_perl <= tmr_writedata;
                3'd3: m_perh <= tmr_writedata;
                default: ;
            endcase
        end else if (m_run) begin
            if (m_cnt == 0) begin
                m_to  <= 1'b1;
                m_run <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (tmr_chipselect && !tmr_write_n) wr_q.push_back({tmr_address, tmr_writedata});
        if (tmr_chipselect) cs_cnt++;
        for (int i = 0; i < 4; i++) begin
            if (done[i]) begin
                done_idx_q.push_back(i);
                done_cyc_q.push_back(cyc);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wr_at(input int i);
        return (i < wr_q.size()) ? {13'd0, wr_q[i]} : 32'hdead_beef;
    endfunction

    function automatic int didx(input int i);
        return (i < done_idx_q.size()) ? done_idx_q[i] : -1;
    endfunction

    function automatic int dcyc(input int i);
        return (i < done_cyc_q.size()) ? done_cyc_q[i] : -1000000;
    endfunction

    task automatic req_one(input int i, input logic [31:0] d);
        req_delay[32*i +: 32] = d;
        req = '0;
        req[i] = 1'b1;
        req_cyc = cyc;
        step();
        req = '0;
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int k = 0;
        while (done_idx_q.size() < target && k < budget) begin
            step();
            k++;
        end
        chk(tag, done_idx_q.size(), target);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, {28'd0, busy}, 32'h0);
        chk({tag, "_done"}, {28'd0, done}, 32'h0);
        chk({tag, "_ovr"}, {28'd0, overrun}, 32'h0);
        chk({tag, "_cs"}, {31'd0, tmr_chipselect}, 32'h0);
        chk({tag, "_wn"}, {31'd0, tmr_write_n}, 32'h1);
        chk({tag, "_addr"}, {29'd0, tmr_address}, 32'h0);
        chk({tag, "_data"}, {16'd0, tmr_writedata}, 32'h0);
    endtask

    initial begin
        int wb, db, cb, lat, c0, c1;

        step();
        step();
        chk_reset_outputs("rst");
        reset = 1'b0;
        step();

        // Four simultaneous requests: served 0..3, each a full 6-write sequence.
        wb = wr_q.size();
        db = done_idx_q.size();
        req_delay = {32'd40, 32'd30, 32'd20, 32'd10};
        req = 4'hf;
        step();
        req = '0;
        chk("all_busy", {28'd0, busy}, 32'hf);
        wait_done(db + 4, 600, "all_done_cnt");
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("order%0d", k), didx(db + k), k);
            chk($sformatf("seq_stop%0d", k), wr_at(wb + 6*k), {13'd0, 3'd1, 16'h0008});
            chk($sformatf("seq_start%0d", k), wr_at(wb + 6*k + 4), {13'd0, 3'd1, 16'h0005});
        end
        chk("all_wr_cnt", wr_q.size() - wb, 24);

        // Single delay 100 on requester 1.
        step();
        wb = wr_q.size();
        db = done_idx_q.size();
        req_one(1, 32'd100);
        chk("d100_busy", {28'd0, busy}, 32'h2);
        wait_done(db + 1, 200, "d100_done");
        chk("d100_idx", didx(db), 1);
        lat = dcyc(db) - req_cyc;
        chk("d100_lat_range", (lat >= 100 && lat <= 112), 1);
        chk("d100_w0", wr_at(wb + 0), {13'd0, 3'd1, 16'h0008});
        chk("d100_w1", wr_at(wb + 1), {13'd0, 3'd2, 16'h0063});
        chk("d100_w2", wr_at(wb + 2), {13'd0, 3'd3, 16'h0000});
        chk("d100_w3", wr_at(wb + 3), {13'd0, 3'd0, 16'h0000});
        chk("d100_w4", wr_at(wb + 4), {13'd0, 3'd1, 16'h0005});
        chk("d100_w5_ack", wr_at(wb + 5), {13'd0, 3'd0, 16'h0000});
        step();
        chk("d100_busy_after", {28'd0, busy}, 32'h0);

        // 32-bit period split across both halves.
        step();
        wb = wr_q.size();
        db = done_idx_q.size();
        req_one(0, 32'h0001_0005);
        wait_done(db + 1, 66000, "big_done");
        lat = dcyc(db) - req_cyc;
        chk("big_lat_min", (lat >= 65541), 1);
        chk("big_lat_max", (lat <= 65541 + 12), 1);
        chk("big_perl", wr_at(wb + 1), {13'd0, 3'd2, 16'h0004});
        chk("big_perh", wr_at(wb + 2), {13'd0, 3'd3, 16'h0001});

        // Delays 0 and 1 bypass the timer.
        for (int d = 0; d < 2; d++) begin
            step();
            step();
            cb = cs_cnt;
            db = done_idx_q.size();
            req_one(2, d);
            wait_done(db + 1, 20, $sformatf("short%0d_done", d));
            chk($sformatf("short%0d_idx", d), didx(db), 2);
            chk($sformatf("short%0d_lat", d), dcyc(db) - req_cyc, 2);
            chk($sformatf("short%0d_cs", d), cs_cnt - cb, 0);
        end

        // Overrun: second request while busy is dropped and flagged.
        step();
        step();
        db = done_idx_q.size();
        req_one(3, 32'd30);
        req_one(3, 32'd5);
        chk("ovr_set", {28'd0, overrun}, 32'h8);
        chk("ovr_busy", {28'd0, busy}, 32'h8);
        wait_done(db + 1, 100, "ovr_done");
        lat = dcyc(db) - req_cyc;
        chk("ovr_lat_orig", (lat >= 29 && lat <= 42), 1);
        for (int k = 0; k < 60; k++) step();
        chk("ovr_single_done", done_idx_q.size() - db, 1);
        chk("ovr_sticky", {28'd0, overrun}, 32'h8);
        chk("ovr_busy_clr", {28'd0, busy}, 32'h0);

        // Reset while waiting on the timer, then recover with the timer left expired.
        step();
        db = done_idx_q.size();
        req_one(0, 32'd200);
        for (int k = 0; k < 30; k++) step();
        reset = 1'b1;
        step();
        chk_reset_outputs("midrst");
        reset = 1'b0;
        for (int k = 0; k < 250; k++) step();
        chk("midrst_no_done", done_idx_q.size() - db, 0);
        wb = wr_q.size();
        db = done_idx_q.size();
        req_one(0, 32'd50);
        wait_done(db + 1, 120, "rec_done");
        chk("rec_idx", didx(db), 0);
        lat = dcyc(db) - req_cyc;
        chk("rec_lat_range", (lat >= 50 && lat <= 62), 1);
        chk("rec_clr", wr_at(wb + 3), {13'd0, 3'd0, 16'h0000});
        chk("rec_wr_cnt", wr_q.size() - wb, 6);
        c0 = dcyc(db);
        c1 = req_cyc;
        chk("rec_not_early", (c0 - c1 >= 50), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
